// File: rtl/player_input_arbiter_pkg.sv
// Shared definitions for the player input arbiter.
// Holds the USB usage codes for the arrow keys.
// Also holds the jump FSM state type and the horizontal-selection state type.
package player_input_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_t;

    typedef enum logic [1:0] {
        H_NONE  = 2'd0,
        H_LEFT  = 2'd1,
        H_RIGHT = 2'd2
    } horiz_sel_t;

endpackage

// File: rtl/player_input_arbiter_if.sv
// Player keycode interface.
// Carries the raw USB report and the on_ground flag into the arbiter.
// Carries the reduced movement keycode and its status flags out of the arbiter.
//   master : arbiter side (drives keycode_out, jumping, facing_left, held_mask)
//   slave  : report source / motion block side
interface player_input_arbiter_if #(
    parameter int NUM_SLOTS = 6
);
    logic [8*NUM_SLOTS-1:0] keycodes_in;
    logic                   on_ground;
    logic [7:0]             keycode_out;
    logic                   jumping;
    logic                   facing_left;
    logic [3:0]             held_mask;

    modport master (
        input  keycodes_in, on_ground,
        output keycode_out, jumping, facing_left, held_mask
    );

    modport slave (
        output keycodes_in, on_ground,
        input  keycode_out, jumping, facing_left, held_mask
    );
endinterface

// File: rtl/player_input_arbiter_key_match.sv
// key_slot_match: reports whether any slot of a keyboard report holds a given usage code.
//   keycodes_i : NUM_SLOTS x 8-bit report, slot 0 in bits [7:0]
//   code_i     : usage code to look for (8'h00 never matches, it marks an empty slot)
//   hit_o      : 1 when at least one slot equals code_i
module key_slot_match #(
    parameter int NUM_SLOTS = 6
) (
    input  logic [8*NUM_SLOTS-1:0] keycodes_i,
    input  logic [7:0]             code_i,
    output logic                   hit_o
);

    // OR-reduce the per-slot compares
    always_comb begin
        hit_o = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_o = hit_o | ((code_i != 8'h00) && (keycodes_i[8*i +: 8] == code_i));
        end
    end

endmodule

// File: rtl/player_input_arbiter.sv
// player_input_arbiter: reduces a multi-slot USB keyboard report to one movement keycode per frame.
// It adds variable-height jump sequencing.
// It resolves left/right so that the last-pressed key wins.
// It keeps a facing flag for the sprite renderer.
//   frame_clk : frame clock, rising edge
//   Reset     : asynchronous, active-high
//   bus       : player keycode interface (master side)
module player_input_arbiter
    import player_input_pkg::*;
#(
    parameter int NUM_SLOTS       = 6,
    parameter int JUMP_FRAMES     = 24,
    parameter int MIN_JUMP_FRAMES = 6
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    player_input_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(JUMP_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(JUMP_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_JUMP_FRAMES - 1);

    logic hit_u_s, hit_d_s, hit_r_s, hit_l_s;
    logic [3:0] hold_s;      // {U,D,R,L}
    logic [3:0] rise_s;

    logic [3:0]       hold_q;
    jump_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    horiz_sel_t       sel_q, sel_d;
    logic             facing_q, facing_d;
    logic [7:0]       keycode_q, keycode_d;
    logic             jumping_q;

    key_slot_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_up (
        .keycodes_i(bus.keycodes_in), .code_i(KEY_UP),    .hit_o(hit_u_s));
    key_slot_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_down (
        .keycodes_i(bus.keycodes_in), .code_i(KEY_DOWN),  .hit_o(hit_d_s));
    key_slot_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_right (
        .keycodes_i(bus.keycodes_in), .code_i(KEY_RIGHT), .hit_o(hit_r_s));
    key_slot_match #(.NUM_SLOTS(NUM_SLOTS)) u_match_left (
        .keycodes_i(bus.keycodes_in), .code_i(KEY_LEFT),  .hit_o(hit_l_s));

    assign hold_s = {hit_u_s, hit_d_s, hit_r_s, hit_l_s};
    assign rise_s = hold_s & ~hold_q;

    // Horizontal selection: the newest press wins, and a release falls back to the other held key
    always_comb begin
        sel_d = sel_q;
        if (rise_s[0] && !rise_s[1]) begin
            sel_d = H_LEFT;
        end else if (rise_s[1] && !rise_s[0]) begin
            sel_d = H_RIGHT;
        end else if (rise_s[0] && rise_s[1]) begin
            // Simultaneous press: keep the current side, or follow the sprite's facing
            if (sel_q == H_NONE) begin
                sel_d = facing_q ? H_LEFT : H_RIGHT;
            end else begin
                sel_d = sel_q;
            end
        end else if (sel_q == H_LEFT && !hold_s[0]) begin
            sel_d = hold_s[1] ? H_RIGHT : H_NONE;
        end else if (sel_q == H_RIGHT && !hold_s[1]) begin
            sel_d = hold_s[0] ? H_LEFT : H_NONE;
        end else begin
            sel_d = sel_q;
        end
    end

    // Facing follows the selected side and keeps its value while nothing is selected
    always_comb begin
        facing_d = facing_q;
        case (sel_d)
            H_LEFT:  facing_d = 1'b1;
            H_RIGHT: facing_d = 1'b0;
            default: facing_d = facing_q;
        endcase
    end

    // Jump FSM next state and frame counter; the counter only advances below CNT_LAST, so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            GROUND: begin
                if (rise_s[3] && bus.on_ground) begin
                    state_d = RISE;
                    cnt_d   = '0;
                end else begin
                    state_d = GROUND;
                end
            end
            RISE: begin
                if ((cnt_q == CNT_LAST) || (!hold_s[3] && (cnt_q >= CNT_MIN))) begin
                    state_d = FALL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FALL: begin
                if (bus.on_ground) begin
                    state_d = GROUND;
                end else begin
                    state_d = FALL;
                end
            end
            default: begin
                state_d = GROUND;
                cnt_d   = '0;
            end
        endcase
    end

    // Output keycode priority: jump, then horizontal, then crouch (ground only)
    always_comb begin
        keycode_d = 8'h00;
        if (state_d == RISE) begin
            keycode_d = KEY_UP;
        end else if (sel_d == H_LEFT) begin
            keycode_d = KEY_LEFT;
        end else if (sel_d == H_RIGHT) begin
            keycode_d = KEY_RIGHT;
        end else if (hold_s[2] && state_d == GROUND) begin
            keycode_d = KEY_DOWN;
        end else begin
            keycode_d = 8'h00;
        end
    end

    // Frame state and registered outputs
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hold_q    <= 4'b0000;
            state_q   <= GROUND;
            cnt_q     <= '0;
            sel_q     <= H_NONE;
            facing_q  <= 1'b0;
            keycode_q <= 8'h00;
            jumping_q <= 1'b0;
        end else begin
            hold_q    <= hold_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            facing_q  <= facing_d;
            keycode_q <= keycode_d;
            jumping_q <= (state_d != GROUND);
        end
    end

    assign bus.keycode_out = keycode_q;
    assign bus.jumping     = jumping_q;
    assign bus.facing_left = facing_q;
    assign bus.held_mask   = hold_q;

endmodule

// File: tb/tb_player_input_arbiter.sv
module tb_player_input_arbiter;

    typedef struct packed {
        logic [7:0] kc;
        logic       j;
        logic       f;
        logic [3:0] h;
    } exp_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    player_input_arbiter_if #(.NUM_SLOTS(6)) bus_if ();

    player_input_arbiter #(
        .NUM_SLOTS(6), .JUMP_FRAMES(24), .MIN_JUMP_FRAMES(6)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus_if)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [47:0] sk(input int i, input logic [7:0] c);
        sk = 48'(c) << (8 * i);
    endfunction

    task automatic cmp(input exp_t e, input string tag);
        checks = checks + 1;
        if (bus_if.keycode_out !== e.kc || bus_if.jumping !== e.j ||
            bus_if.facing_left !== e.f || bus_if.held_mask !== e.h) begin
            errors = errors + 1;
            $display("FAIL %s: got kc=%h j=%b f=%b h=%b, want kc=%h j=%b f=%b h=%b", tag,
                     bus_if.keycode_out, bus_if.jumping, bus_if.facing_left, bus_if.held_mask,
                     e.kc, e.j, e.f, e.h);
        end
    endtask

    // Drive one frame's inputs and queue the output expected after the next edge
    task automatic step(input logic rst, input logic [47:0] kc, input logic og,
                        input logic [7:0] ek, input logic ej, input logic ef, input logic [3:0] eh);
        exp_t e;
        @(negedge frame_clk);
        Reset              = rst;
        bus_if.keycodes_in = kc;
        bus_if.on_ground   = og;
        e.kc = ek; e.j = ej; e.f = ef; e.h = eh;
        exp_q.push_back(e);
    endtask

    // Monitor: one output per frame, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e, "frame");
            end
        end
    end

    initial begin
        exp_t z;
        logic [47:0] U3, U0, L, R, D;
        z = '0;
        U3 = sk(3, 8'h52); U0 = sk(0, 8'h52);
        L  = sk(0, 8'h50); R  = sk(5, 8'h4F); D = sk(2, 8'h51);
        bus_if.keycodes_in = 48'h0;
        bus_if.on_ground   = 1'b1;

        // reset state
        step(1'b1, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);

        // reset mid-RISE at cnt=10
        step(1'b0, U3, 1'b1, 8'h52, 1'b1, 1'b0, 4'b1000);
        for (int i = 0; i < 10; i++) step(1'b0, U3, 1'b0, 8'h52, 1'b1, 1'b0, 4'b1000);
        @(negedge frame_clk);
        Reset = 1'b1;
        bus_if.keycodes_in = 48'h0;
        bus_if.on_ground   = 1'b1;
        #1;
        cmp(z, "async_reset");
        step(1'b1, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);

        // long hold: exactly 24 jump frames, landing drops jumping
        step(1'b0, U3, 1'b1, 8'h52, 1'b1, 1'b0, 4'b1000);
        for (int i = 1; i < 24; i++) step(1'b0, U3, 1'b0, 8'h52, 1'b1, 1'b0, 4'b1000);
        for (int i = 24; i < 30; i++) step(1'b0, U3, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1000);
        for (int i = 30; i < 40; i++) step(1'b0, U3, 1'b1, 8'h00, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);

        // tap: minimum jump, U held through landing does not retrigger
        step(1'b0, U0, 1'b1, 8'h52, 1'b1, 1'b0, 4'b1000);
        for (int i = 1; i < 6; i++) step(1'b0, 48'h0, 1'b0, 8'h52, 1'b1, 1'b0, 4'b0000);
        step(1'b0, 48'h0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0000);
        step(1'b0, U0, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1000);
        for (int i = 0; i < 4; i++) step(1'b0, U0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b1000);
        step(1'b0, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);

        // last-pressed-wins left/right
        for (int i = 0; i < 3; i++) step(1'b0, L, 1'b1, 8'h50, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 2; i++) step(1'b0, L | R, 1'b1, 8'h4F, 1'b0, 1'b0, 4'b0011);
        step(1'b0, L, 1'b1, 8'h50, 1'b0, 1'b1, 4'b0001);
        step(1'b0, 48'h0, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0000);

        // simultaneous press from reset follows facing (right)
        step(1'b1, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 2; i++)
            step(1'b0, sk(0, 8'h50) | sk(1, 8'h4F), 1'b1, 8'h4F, 1'b0, 1'b0, 4'b0011);
        step(1'b0, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);

        // down: ground only, suppressed in FALL, duplicates harmless
        step(1'b0, D, 1'b1, 8'h51, 1'b0, 1'b0, 4'b0100);
        step(1'b0, D | U0, 1'b1, 8'h52, 1'b1, 1'b0, 4'b1100);
        for (int i = 0; i < 5; i++) step(1'b0, D, 1'b0, 8'h52, 1'b1, 1'b0, 4'b0100);
        step(1'b0, D, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0100);
        step(1'b0, D, 1'b0, 8'h00, 1'b1, 1'b0, 4'b0100);
        step(1'b0, D, 1'b1, 8'h51, 1'b0, 1'b0, 4'b0100);
        step(1'b0, sk(0, 8'h51) | sk(1, 8'h51), 1'b1, 8'h51, 1'b0, 1'b0, 4'b0100);
        step(1'b0, 48'h0, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0000);

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge frame_clk);
        #2;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
